// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifetch_pkg;

    // Fetch FSM state encodings (2-bit).
    typedef enum logic [1:0] {
        IFS_IDLE = 2'b00,
        IFS_FILL = 2'b01,
        IFS_RUN  = 2'b10,
        IFS_HALT = 2'b11
    } ifs_t;

    // Default widths: PC/ROM address, instruction word, retired counter.
    localparam int DEF_PCW  = 8;
    localparam int DEF_IW   = 16;
    localparam int DEF_CNTW = 16;

    // Program counter control; clr has priority over inc.
    typedef struct packed {
        logic clr;
        logic inc;
    } pc_ctl_t;

endpackage

// File: rtl/ifetch_pcnt.sv
// Program counter register with clear / increment / hold and a wrap flag.
module pcnt
    import ifetch_pkg::*;
#(
    parameter int PCW = DEF_PCW
) (
    input  logic           clk,
    input  logic           rst,
    input  pc_ctl_t        ctl,
    output logic [PCW-1:0] pc,
    output logic           wrap
);

    // wrap flags an increment that rolls the counter from all-ones back to 0.
    assign wrap = ctl.inc & ~ctl.clr & (&pc);

    // PC update: clear wins over increment, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (ctl.clr) begin
            pc <= '0;
        end else if (ctl.inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM,
// presents instructions to the decoder with a one-entry stall buffer,
// stops on decoder HALT, tracks PC wrap and counts retired instructions.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int PCW  = DEF_PCW,
    parameter int IW   = DEF_IW,
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            h,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic [IW-1:0]   o,
    output logic            o_valid,
    output logic [PCW-1:0]  pc_dec,
    output logic            halted,
    output logic            ovf,
    output logic [CNTW-1:0] icnt
);

    ifs_t           state;
    ifs_t           state_next;
    pc_ctl_t        pc_ctl;
    logic [PCW-1:0] pc;
    logic           pc_wrap;
    logic           enter_fill;
    logic           retire;
    logic           advance;
    logic           capture;
    logic           hold;
    logic [IW-1:0]  ir;

    // Saturating increment for the retired-instruction counter.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pcnt #(
        .PCW (PCW)
    ) u_pcnt (
        .clk  (clk),
        .rst  (rst),
        .ctl  (pc_ctl),
        .pc   (pc),
        .wrap (pc_wrap)
    );

    assign halted = (state == IFS_HALT);

    // Next-state logic plus per-state ROM address, decoder outputs and PC control.
    always_comb begin
        state_next = state;
        pc_ctl     = '0;
        enter_fill = 1'b0;
        retire     = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        imem_addr  = pc;
        o_valid    = 1'b0;
        o          = '0;
        unique case (state)
            IFS_IDLE, IFS_HALT: begin
                if (start) begin
                    state_next = IFS_FILL;
                    enter_fill = 1'b1;
                    pc_ctl.clr = 1'b1;
                end
            end
            IFS_FILL: begin
                // ROM is reading address 0 this cycle; PC moves on to 1.
                imem_addr  = '0;
                pc_ctl.inc = 1'b1;
                state_next = IFS_RUN;
            end
            IFS_RUN: begin
                o_valid = 1'b1;
                o       = hold ? ir : imem_rdata;
                if (!stall) begin
                    // A stalled HALT waits; it only takes effect when it retires.
                    retire = 1'b1;
                    if (h) begin
                        state_next = IFS_HALT;
                    end else begin
                        advance    = 1'b1;
                        pc_ctl.inc = 1'b1;
                    end
                end else begin
                    // ROM output moves on during a stall, so park it on the first stall cycle.
                    capture = ~hold;
                end
            end
            default: state_next = IFS_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IFS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall skid buffer: holds the presented word while the ROM output moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= 1'b0;
            ir   <= '0;
        end else if (enter_fill) begin
            hold <= 1'b0;
        end else if (capture) begin
            ir   <= imem_rdata;
            hold <= 1'b1;
        end else if (retire) begin
            hold <= 1'b0;
        end
    end

    // Address of the instruction on o follows the PC one step behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_dec <= '0;
        end else if (enter_fill) begin
            pc_dec <= '0;
        end else if (advance) begin
            pc_dec <= pc;
        end
    end

    // Sticky wrap flag, cleared on each start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (enter_fill) begin
            ovf <= 1'b0;
        end else if (advance && pc_wrap) begin
            ovf <= 1'b1;
        end
    end

    // Retired-instruction counter, saturating; a retiring HALT is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt <= '0;
        end else if (enter_fill) begin
            icnt <= '0;
        end else if (retire) begin
            icnt <= sat_inc(icnt);
        end
    end

endmodule
